// File: rtl/dispatcher_pkg.sv
// Shared types and opcode classification for the dispatch stage.
// Bus widths, internal opcode values, the dispatch slot record and the
// slot-state encoding live here so the top and the operand resolver agree.
package dispatcher_pkg;

  localparam int unsigned NICK_W = 4;   // ROB tag width; tag 0 = value ready
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IMM_W  = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned NAME_W = 5;

  typedef logic [NICK_W-1:0] NickBus;
  typedef logic [DATA_W-1:0] DataBus;
  typedef logic [NAME_W-1:0] NameBus;
  typedef logic [OP_W-1:0]   OpBus;
  typedef logic [ADDR_W-1:0] AddrBus;
  typedef logic [IMM_W-1:0]  ImmBus;

  localparam OpBus OP_ADD  = 6'd1;
  localparam OpBus OP_SUB  = 6'd2;
  localparam OpBus OP_ADDI = 6'd3;
  localparam OpBus OP_LUI  = 6'd4;
  localparam OpBus OP_JAL  = 6'd5;
  localparam OpBus OP_JALR = 6'd6;
  localparam OpBus OP_BEQ  = 6'd10;
  localparam OpBus OP_BNE  = 6'd11;
  localparam OpBus OP_BLT  = 6'd12;
  localparam OpBus OP_BGE  = 6'd13;
  localparam OpBus OP_BLTU = 6'd14;
  localparam OpBus OP_BGEU = 6'd15;
  localparam OpBus OP_LB   = 6'd20;
  localparam OpBus OP_LH   = 6'd21;
  localparam OpBus OP_LW   = 6'd22;
  localparam OpBus OP_LBU  = 6'd23;
  localparam OpBus OP_LHU  = 6'd24;
  localparam OpBus OP_SB   = 6'd28;
  localparam OpBus OP_SH   = 6'd29;
  localparam OpBus OP_SW   = 6'd30;

  typedef enum logic {ST_EMPTY, ST_HELD} state_e;

  typedef struct packed {
    OpBus   op;
    AddrBus pc;
    ImmBus  imm;
    logic   pd;
    NameBus rd;
    NickBus rs1_nick;
    DataBus rs1_dt;
    NickBus rs2_nick;
    DataBus rs2_dt;
  } slot_t;

  function automatic logic is_load(input OpBus op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input OpBus op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_branch(input OpBus op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic logic is_mem(input OpBus op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic writes_rd(input OpBus op);
    return !is_store(op) && !is_branch(op);
  endfunction

endpackage

// File: rtl/dispatcher_operand_resolver.sv
// Combinational operand wakeup for one source of the dispatch slot.
// Priority: tag 0 (stored value) > ALU CDB > LSB CDB (DISPATCH_LSB_CDB_EN)
// > ROB ready value > still pending (v_o=0, q_o=tag).
// Ports: nick_i/dt_i stored pair; cdb_* ALU broadcast; lsb_cdb_* load
// broadcast (macro only); rob_rdy_i/rob_dt_i ROB query result; v_o/q_o.
module dispatcher_operand_resolver
  import dispatcher_pkg::*;
(
  input  logic [NICK_W-1:0] nick_i,
  input  logic [DATA_W-1:0] dt_i,
  input  logic              cdb_en_i,
  input  logic [NICK_W-1:0] cdb_nick_i,
  input  logic [DATA_W-1:0] cdb_dt_i,
`ifdef DISPATCH_LSB_CDB_EN
  input  logic              lsb_cdb_en_i,
  input  logic [NICK_W-1:0] lsb_cdb_nick_i,
  input  logic [DATA_W-1:0] lsb_cdb_dt_i,
`endif
  input  logic              rob_rdy_i,
  input  logic [DATA_W-1:0] rob_dt_i,
  output logic [DATA_W-1:0] v_o,
  output logic [NICK_W-1:0] q_o
);

  always_comb begin
    v_o = '0;
    q_o = nick_i;
    if (nick_i == '0) begin
      v_o = dt_i;
    end else if (cdb_en_i && (cdb_nick_i == nick_i)) begin
      v_o = cdb_dt_i;
      q_o = '0;
`ifdef DISPATCH_LSB_CDB_EN
    end else if (lsb_cdb_en_i && (lsb_cdb_nick_i == nick_i)) begin
      v_o = lsb_cdb_dt_i;
      q_o = '0;
`endif
    end else if (rob_rdy_i) begin
      v_o = rob_dt_i;
      q_o = '0;
    end
  end

endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: holds one decoded instruction, wakes up its operands from
// the CDB/ROB, allocates a ROB entry, renames rd and issues to RS or LSB.
// Optional macro DISPATCH_LSB_CDB_EN adds a second (load) broadcast input.
// Ports: clk/rst (sync, active-high), rdy (freeze), clr (flush);
// i_rf_* incoming instruction; o_stall upstream hold; o_rf_nick_* rename;
// i_rob_*/o_rob_* ROB query and allocation; i_cdb_* ALU broadcast;
// i_rs_full/i_lsb_full targets; o_rs_en/o_lsb_en + shared issue payload.
module dispatcher
  import dispatcher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              i_rf_en,
  input  logic [NAME_W-1:0] i_rf_rs1_regnm,
  input  logic [NAME_W-1:0] i_rf_rs2_regnm,
  input  logic [NICK_W-1:0] i_rf_rs1_nick,
  input  logic [NICK_W-1:0] i_rf_rs2_nick,
  input  logic [DATA_W-1:0] i_rf_rs1_dt,
  input  logic [DATA_W-1:0] i_rf_rs2_dt,
  input  logic [NAME_W-1:0] i_rf_rd_regnm,
  input  logic [OP_W-1:0]   i_rf_op,
  input  logic [ADDR_W-1:0] i_rf_pc,
  input  logic [IMM_W-1:0]  i_rf_imm,
  input  logic              i_rf_pd,
  output logic              o_stall,
  output logic              o_rf_nick_en,
  output logic [NAME_W-1:0] o_rf_nick_regnm,
  output logic [NICK_W-1:0] o_rf_nick,
  input  logic              i_rob_full,
  input  logic [NICK_W-1:0] i_rob_free_nick,
  output logic [NICK_W-1:0] o_rob_q1_nick,
  output logic [NICK_W-1:0] o_rob_q2_nick,
  input  logic              i_rob_q1_rdy,
  input  logic              i_rob_q2_rdy,
  input  logic [DATA_W-1:0] i_rob_q1_dt,
  input  logic [DATA_W-1:0] i_rob_q2_dt,
  output logic              o_rob_en,
  output logic [NAME_W-1:0] o_rob_rd_regnm,
  output logic [OP_W-1:0]   o_rob_op,
  output logic [ADDR_W-1:0] o_rob_pc,
  output logic              o_rob_pd,
  input  logic              i_cdb_en,
  input  logic [NICK_W-1:0] i_cdb_nick,
  input  logic [DATA_W-1:0] i_cdb_dt,
`ifdef DISPATCH_LSB_CDB_EN
  input  logic              i_lsb_cdb_en,
  input  logic [NICK_W-1:0] i_lsb_cdb_nick,
  input  logic [DATA_W-1:0] i_lsb_cdb_dt,
`endif
  input  logic              i_rs_full,
  input  logic              i_lsb_full,
  output logic              o_rs_en,
  output logic              o_lsb_en,
  output logic [OP_W-1:0]   o_op,
  output logic [DATA_W-1:0] o_vj,
  output logic [NICK_W-1:0] o_qj,
  output logic [DATA_W-1:0] o_vk,
  output logic [NICK_W-1:0] o_qk,
  output logic [IMM_W-1:0]  o_imm,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_pd,
  output logic [NICK_W-1:0] o_nick
);

  state_e state_q, state_d;
  slot_t  s_q, s_d;

  logic   valid, to_lsb, tgt_full, fire, rename_fire, accept;
  NickBus q1, q2;
  DataBus v1, v2;

  assign valid       = (state_q == ST_HELD);
  assign to_lsb      = is_mem(s_q.op);
  assign tgt_full    = to_lsb ? i_lsb_full : i_rs_full;
  assign fire        = valid && rdy && !rst && !clr && !i_rob_full && !tgt_full;
  assign rename_fire = fire && writes_rd(s_q.op) && (s_q.rd != '0);
  assign accept      = i_rf_en && rdy && !rst && !clr && (!valid || fire);

  dispatcher_operand_resolver u_rs1 (
    .nick_i(s_q.rs1_nick), .dt_i(s_q.rs1_dt),
    .cdb_en_i(i_cdb_en), .cdb_nick_i(i_cdb_nick), .cdb_dt_i(i_cdb_dt),
`ifdef DISPATCH_LSB_CDB_EN
    .lsb_cdb_en_i(i_lsb_cdb_en), .lsb_cdb_nick_i(i_lsb_cdb_nick),
    .lsb_cdb_dt_i(i_lsb_cdb_dt),
`endif
    .rob_rdy_i(i_rob_q1_rdy), .rob_dt_i(i_rob_q1_dt),
    .v_o(v1), .q_o(q1)
  );

  dispatcher_operand_resolver u_rs2 (
    .nick_i(s_q.rs2_nick), .dt_i(s_q.rs2_dt),
    .cdb_en_i(i_cdb_en), .cdb_nick_i(i_cdb_nick), .cdb_dt_i(i_cdb_dt),
`ifdef DISPATCH_LSB_CDB_EN
    .lsb_cdb_en_i(i_lsb_cdb_en), .lsb_cdb_nick_i(i_lsb_cdb_nick),
    .lsb_cdb_dt_i(i_lsb_cdb_dt),
`endif
    .rob_rdy_i(i_rob_q2_rdy), .rob_dt_i(i_rob_q2_dt),
    .v_o(v2), .q_o(q2)
  );

  // Incoming source pairs at accept. The regfile has not yet seen the rename
  // being issued this cycle, so a source naming the firing rd takes the new
  // tag; otherwise a broadcast landing this cycle would otherwise be missed.
  NameBus in_regnm [2];
  NickBus in_nick  [2];
  DataBus in_dt    [2];
  NickBus lat_nick [2];
  DataBus lat_dt   [2];

  assign in_regnm[0] = i_rf_rs1_regnm;
  assign in_regnm[1] = i_rf_rs2_regnm;
  assign in_nick[0]  = i_rf_rs1_nick;
  assign in_nick[1]  = i_rf_rs2_nick;
  assign in_dt[0]    = i_rf_rs1_dt;
  assign in_dt[1]    = i_rf_rs2_dt;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      lat_nick[i] = in_nick[i];
      lat_dt[i]   = in_dt[i];
      if (rename_fire && (in_regnm[i] == s_q.rd)) begin
        lat_nick[i] = i_rob_free_nick;
        lat_dt[i]   = '0;
      end else if ((in_nick[i] != '0) && i_cdb_en && (i_cdb_nick == in_nick[i])) begin
        lat_nick[i] = '0;
        lat_dt[i]   = i_cdb_dt;
`ifdef DISPATCH_LSB_CDB_EN
      end else if ((in_nick[i] != '0) && i_lsb_cdb_en && (i_lsb_cdb_nick == in_nick[i])) begin
        lat_nick[i] = '0;
        lat_dt[i]   = i_lsb_cdb_dt;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (clr)         state_d = ST_EMPTY;
      else if (accept) state_d = ST_HELD;
      else if (fire)   state_d = ST_EMPTY;
    end
  end

  always_comb begin
    s_d = s_q;
    if (accept) begin
      s_d.op       = i_rf_op;
      s_d.pc       = i_rf_pc;
      s_d.imm      = i_rf_imm;
      s_d.pd       = i_rf_pd;
      s_d.rd       = i_rf_rd_regnm;
      s_d.rs1_nick = lat_nick[0];
      s_d.rs1_dt   = lat_dt[0];
      s_d.rs2_nick = lat_nick[1];
      s_d.rs2_dt   = lat_dt[1];
    end else if (valid && rdy && !clr && !fire) begin
      // Fold this cycle's wakeups back into the slot so they are not lost.
      s_d.rs1_nick = q1;
      s_d.rs1_dt   = v1;
      s_d.rs2_nick = q2;
      s_d.rs2_dt   = v2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  assign o_stall         = valid && !fire && !rst;
  assign o_rf_nick_en    = rename_fire;
  assign o_rf_nick_regnm = s_q.rd;
  assign o_rf_nick       = rename_fire ? i_rob_free_nick : '0;
  assign o_rob_q1_nick   = s_q.rs1_nick;
  assign o_rob_q2_nick   = s_q.rs2_nick;
  assign o_rob_en        = fire;
  assign o_rob_rd_regnm  = s_q.rd;
  assign o_rob_op        = s_q.op;
  assign o_rob_pc        = s_q.pc;
  assign o_rob_pd        = s_q.pd;
  assign o_rs_en         = fire && !to_lsb;
  assign o_lsb_en        = fire && to_lsb;
  assign o_op            = s_q.op;
  assign o_vj            = v1;
  assign o_qj            = q1;
  assign o_vk            = v2;
  assign o_qk            = q2;
  assign o_imm           = s_q.imm;
  assign o_pc            = s_q.pc;
  assign o_pd            = s_q.pd;
  assign o_nick          = fire ? i_rob_free_nick : '0;

endmodule

// File: tb/tb_dispatcher.sv
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic   clk, rst, rdy, clr;
  logic   i_rf_en, i_rf_pd;
  NameBus i_rf_rs1_regnm, i_rf_rs2_regnm, i_rf_rd_regnm;
  NickBus i_rf_rs1_nick, i_rf_rs2_nick;
  DataBus i_rf_rs1_dt, i_rf_rs2_dt;
  OpBus   i_rf_op;
  AddrBus i_rf_pc;
  ImmBus  i_rf_imm;
  logic   o_stall, o_rf_nick_en;
  NameBus o_rf_nick_regnm;
  NickBus o_rf_nick;
  logic   i_rob_full;
  NickBus i_rob_free_nick, o_rob_q1_nick, o_rob_q2_nick;
  logic   i_rob_q1_rdy, i_rob_q2_rdy;
  DataBus i_rob_q1_dt, i_rob_q2_dt;
  logic   o_rob_en, o_rob_pd;
  NameBus o_rob_rd_regnm;
  OpBus   o_rob_op;
  AddrBus o_rob_pc;
  logic   i_cdb_en;
  NickBus i_cdb_nick;
  DataBus i_cdb_dt;
`ifdef DISPATCH_LSB_CDB_EN
  logic   i_lsb_cdb_en;
  NickBus i_lsb_cdb_nick;
  DataBus i_lsb_cdb_dt;
`endif
  logic   i_rs_full, i_lsb_full, o_rs_en, o_lsb_en, o_pd;
  OpBus   o_op;
  DataBus o_vj, o_vk;
  NickBus o_qj, o_qk, o_nick;
  ImmBus  o_imm;
  AddrBus o_pc;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .i_rf_en(i_rf_en), .i_rf_rs1_regnm(i_rf_rs1_regnm), .i_rf_rs2_regnm(i_rf_rs2_regnm),
    .i_rf_rs1_nick(i_rf_rs1_nick), .i_rf_rs2_nick(i_rf_rs2_nick),
    .i_rf_rs1_dt(i_rf_rs1_dt), .i_rf_rs2_dt(i_rf_rs2_dt),
    .i_rf_rd_regnm(i_rf_rd_regnm), .i_rf_op(i_rf_op), .i_rf_pc(i_rf_pc),
    .i_rf_imm(i_rf_imm), .i_rf_pd(i_rf_pd),
    .o_stall(o_stall), .o_rf_nick_en(o_rf_nick_en),
    .o_rf_nick_regnm(o_rf_nick_regnm), .o_rf_nick(o_rf_nick),
    .i_rob_full(i_rob_full), .i_rob_free_nick(i_rob_free_nick),
    .o_rob_q1_nick(o_rob_q1_nick), .o_rob_q2_nick(o_rob_q2_nick),
    .i_rob_q1_rdy(i_rob_q1_rdy), .i_rob_q2_rdy(i_rob_q2_rdy),
    .i_rob_q1_dt(i_rob_q1_dt), .i_rob_q2_dt(i_rob_q2_dt),
    .o_rob_en(o_rob_en), .o_rob_rd_regnm(o_rob_rd_regnm), .o_rob_op(o_rob_op),
    .o_rob_pc(o_rob_pc), .o_rob_pd(o_rob_pd),
    .i_cdb_en(i_cdb_en), .i_cdb_nick(i_cdb_nick), .i_cdb_dt(i_cdb_dt),
`ifdef DISPATCH_LSB_CDB_EN
    .i_lsb_cdb_en(i_lsb_cdb_en), .i_lsb_cdb_nick(i_lsb_cdb_nick),
    .i_lsb_cdb_dt(i_lsb_cdb_dt),
`endif
    .i_rs_full(i_rs_full), .i_lsb_full(i_lsb_full),
    .o_rs_en(o_rs_en), .o_lsb_en(o_lsb_en), .o_op(o_op),
    .o_vj(o_vj), .o_qj(o_qj), .o_vk(o_vk), .o_qk(o_qk),
    .o_imm(o_imm), .o_pc(o_pc), .o_pd(o_pd), .o_nick(o_nick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic   lsb;
    OpBus   op;
    DataBus vj;
    NickBus qj;
    DataBus vk;
    NickBus qk;
    NickBus nick;
    logic   ren;
    NameBus rnm;
    ImmBus  imm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input OpBus op, input NameBus rd, input NameBus r1, input NameBus r2,
                      input NickBus n1, input NickBus n2, input DataBus d1, input DataBus d2,
                      input ImmBus imm);
    i_rf_en = 1'b1; i_rf_op = op; i_rf_rd_regnm = rd;
    i_rf_rs1_regnm = r1; i_rf_rs2_regnm = r2;
    i_rf_rs1_nick = n1; i_rf_rs2_nick = n2;
    i_rf_rs1_dt = d1; i_rf_rs2_dt = d2; i_rf_imm = imm;
  endtask

  task automatic expect_issue(input logic lsb, input OpBus op, input DataBus vj, input NickBus qj,
                              input DataBus vk, input NickBus qk, input NickBus nick,
                              input logic ren, input NameBus rnm, input ImmBus imm);
    exp_t e;
    e.lsb = lsb; e.op = op; e.vj = vj; e.qj = qj; e.vk = vk; e.qk = qk;
    e.nick = nick; e.ren = ren; e.rnm = rnm; e.imm = imm;
    sb.push_back(e);
  endtask

  // Monitor: every cycle with any issue/allocate/rename strobe consumes one
  // expected record.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (o_rob_en || o_rs_en || o_lsb_en || o_rf_nick_en)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: rob_en=%0b rs_en=%0b lsb_en=%0b ren=%0b expected none at %0t",
                 o_rob_en, o_rs_en, o_lsb_en, o_rf_nick_en, $time);
      end else begin
        e = sb.pop_front();
        chk("rob_en", 32'(o_rob_en), 32'd1);
        chk("rs_en", 32'(o_rs_en), 32'(!e.lsb));
        chk("lsb_en", 32'(o_lsb_en), 32'(e.lsb));
        chk("op", 32'(o_op), 32'(e.op));
        chk("vj", o_vj, e.vj);
        chk("qj", 32'(o_qj), 32'(e.qj));
        chk("vk", o_vk, e.vk);
        chk("qk", 32'(o_qk), 32'(e.qk));
        chk("imm", o_imm, e.imm);
        chk("nick", 32'(o_nick), 32'(e.nick));
        chk("rename_en", 32'(o_rf_nick_en), 32'(e.ren));
        if (e.ren) begin
          chk("rename_regnm", 32'(o_rf_nick_regnm), 32'(e.rnm));
          chk("rename_nick", 32'(o_rf_nick), 32'(e.nick));
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    i_rf_en = 1'b0; i_rf_pd = 1'b0; i_rf_pc = 32'h1000; i_rf_op = OP_ADD;
    i_rf_rs1_regnm = '0; i_rf_rs2_regnm = '0; i_rf_rd_regnm = '0;
    i_rf_rs1_nick = '0; i_rf_rs2_nick = '0; i_rf_rs1_dt = '0; i_rf_rs2_dt = '0;
    i_rf_imm = '0;
    i_rob_full = 1'b0; i_rob_free_nick = 4'd3;
    i_rob_q1_rdy = 1'b0; i_rob_q2_rdy = 1'b0; i_rob_q1_dt = '0; i_rob_q2_dt = '0;
    i_cdb_en = 1'b0; i_cdb_nick = '0; i_cdb_dt = '0;
`ifdef DISPATCH_LSB_CDB_EN
    i_lsb_cdb_en = 1'b0; i_lsb_cdb_nick = '0; i_lsb_cdb_dt = '0;
`endif
    i_rs_full = 1'b0; i_lsb_full = 1'b0;

    // Reset state (instruction offered during reset must be ignored)
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_rob_en", 32'(o_rob_en), 32'd0);
    chk("rst_rs_en", 32'(o_rs_en), 32'd0);
    chk("rst_ren", 32'(o_rf_nick_en), 32'd0);
    chk("rst_nick", 32'(o_nick), 32'd0);
    chk("rst_vj", o_vj, 32'd0);
    chk("rst_q1_nick", 32'(o_rob_q1_nick), 32'd0);
    tick();
    rst = 1'b0; i_rf_en = 1'b0;
    tick();

    // 1: ADD x1,x2,x3 ready operands
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 4'd0, 4'd0, 32'd5, 32'd7, 32'd0);
    expect_issue(1'b0, OP_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3, 1'b1, 5'd1, 32'd0);
    tick();
    i_rf_en = 1'b0;
    @(negedge clk);
    chk("t1_stall_firing", 32'(o_stall), 32'd0);
    tick(); tick();

    // 2: back-to-back dependent ADD takes the bypassed tag
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 4'd0, 4'd0, 32'd5, 32'd7, 32'd0);
    expect_issue(1'b0, OP_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3, 1'b1, 5'd1, 32'd0);
    tick();
    send(OP_ADD, 5'd2, 5'd1, 5'd0, 4'd0, 4'd0, 32'd99, 32'd0, 32'd0);
    expect_issue(1'b0, OP_ADD, 32'd0, 4'd3, 32'd0, 4'd0, 4'd4, 1'b1, 5'd2, 32'd0);
    @(negedge clk);
    chk("t2_stall_b2b", 32'(o_stall), 32'd0);
    tick();
    i_rf_en = 1'b0; i_rob_free_nick = 4'd4;
    tick(); tick();

    // 3: held on full RS, CDB wakeup captured, issues later
    i_rob_free_nick = 4'd5; i_rs_full = 1'b1;
    send(OP_ADD, 5'd4, 5'd5, 5'd6, 4'd3, 4'd0, 32'd0, 32'd2, 32'd0);
    expect_issue(1'b0, OP_ADD, 32'h55, 4'd0, 32'd2, 4'd0, 4'd5, 1'b1, 5'd4, 32'd0);
    tick();
    i_rf_en = 1'b0; i_cdb_en = 1'b1; i_cdb_nick = 4'd3; i_cdb_dt = 32'h55;
    @(negedge clk);
    chk("t3_stall_cdb", 32'(o_stall), 32'd1);
    chk("t3_q1_nick", 32'(o_rob_q1_nick), 32'd3);
    tick();
    i_cdb_en = 1'b0;
    @(negedge clk);
    chk("t3_stall_after", 32'(o_stall), 32'd1);
    chk("t3_q1_after", 32'(o_rob_q1_nick), 32'd0);
    tick();
    i_rs_full = 1'b0;
    tick(); tick();

    // 4: ROB full for 3 cycles, then exactly one issue
    i_rob_free_nick = 4'd6; i_rob_full = 1'b1;
    send(OP_ADD, 5'd6, 5'd1, 5'd2, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0);
    expect_issue(1'b0, OP_ADD, 32'd1, 4'd0, 32'd2, 4'd0, 4'd6, 1'b1, 5'd6, 32'd0);
    tick();
    i_rf_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_robfull", 32'(o_stall), 32'd1);
      chk("t4_rob_en_robfull", 32'(o_rob_en), 32'd0);
      tick();
    end
    i_rob_full = 1'b0;
    @(negedge clk);
    chk("t4_stall_release", 32'(o_stall), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_single_issue", 32'(o_rob_en), 32'd0);
    tick();

    // 5: SW to LSB without rename, then ADDI x0 (no rename, no bypass from store rd)
    i_rob_free_nick = 4'd7;
    send(OP_SW, 5'd7, 5'd6, 5'd5, 4'd0, 4'd0, 32'h100, 32'hAB, 32'd0);
    expect_issue(1'b1, OP_SW, 32'h100, 4'd0, 32'hAB, 4'd0, 4'd7, 1'b0, 5'd0, 32'd0);
    tick();
    send(OP_ADDI, 5'd0, 5'd7, 5'd0, 4'd0, 4'd0, 32'd9, 32'd0, 32'd4);
    expect_issue(1'b0, OP_ADDI, 32'd9, 4'd0, 32'd0, 4'd0, 4'd8, 1'b0, 5'd0, 32'd4);
    tick();
    i_rf_en = 1'b0; i_rob_free_nick = 4'd8;
    tick(); tick();

    // 6: rdy low freezes, then clr flushes the held instruction and drops the incoming one
    i_rob_free_nick = 4'd9;
    send(OP_ADD, 5'd8, 5'd1, 5'd2, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0);
    tick();
    i_rf_en = 1'b0; rdy = 1'b0;
    @(negedge clk);
    chk("t6_stall_rdy0", 32'(o_stall), 32'd1);
    chk("t6_rob_en_rdy0", 32'(o_rob_en), 32'd0);
    tick();
    rdy = 1'b1; clr = 1'b1;
    send(OP_ADD, 5'd9, 5'd1, 5'd2, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0);
    @(negedge clk);
    chk("t6_rob_en_clr", 32'(o_rob_en), 32'd0);
    chk("t6_rs_en_clr", 32'(o_rs_en), 32'd0);
    tick();
    clr = 1'b0; i_rf_en = 1'b0;
    @(negedge clk);
    chk("t6_stall_after_clr", 32'(o_stall), 32'd0);
    chk("t6_rob_en_after_clr", 32'(o_rob_en), 32'd0);
    tick(); tick(); tick();

    // 7: incoming tag matching the CDB latches as ready
    i_rob_free_nick = 4'd10;
    i_cdb_en = 1'b1; i_cdb_nick = 4'd5; i_cdb_dt = 32'h77;
    send(OP_SUB, 5'd10, 5'd3, 5'd4, 4'd5, 4'd0, 32'd0, 32'd1, 32'd0);
    expect_issue(1'b0, OP_SUB, 32'h77, 4'd0, 32'd1, 4'd0, 4'd10, 1'b1, 5'd10, 32'd0);
    tick();
    i_cdb_en = 1'b0; i_rf_en = 1'b0;
    tick(); tick();

    // 8: pending rs2 resolved from ROB ready value
    i_rob_free_nick = 4'd11;
    send(OP_ADD, 5'd11, 5'd1, 5'd2, 4'd0, 4'd6, 32'd3, 32'd0, 32'd0);
    expect_issue(1'b0, OP_ADD, 32'd3, 4'd0, 32'h99, 4'd0, 4'd11, 1'b1, 5'd11, 32'd0);
    tick();
    i_rf_en = 1'b0; i_rob_q2_rdy = 1'b1; i_rob_q2_dt = 32'h99;
    @(negedge clk);
    chk("t8_q2_nick", 32'(o_rob_q2_nick), 32'd6);
    tick();
    i_rob_q2_rdy = 1'b0;
    tick(); tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
